// File: rtl/fifo_dist.sv
// fifo_dist: single-clock FIFO on a distributed RAM (synchronous write,
// asynchronous read) with first-word-fall-through output, occupancy count,
// full/empty/almost flags and one-cycle overflow/underflow pulses.
//
// Handshake: a push is taken on a rising edge when wr_en is high and the
// queue is not full, or it is full and rd_en pops in the same cycle. A pop is
// taken when rd_en is high and the queue is not empty; rd_en acknowledges the
// word currently on data_out. A refused request leaves all state untouched
// and raises overflow/underflow for the following cycle.
module fifo_dist #(
  parameter int DATA_W    = 3,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_TH);
  localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_TH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              push_ok;
  logic              pop_ok;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // Status is derived only from the registered pointers.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AFULL_V);
  assign almost_empty = (count <= AEMPTY_V);

  // When full, a simultaneous pop frees the slot the push writes into.
  assign push_ok = wr_en & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;

  // Head of queue falls through the asynchronous read port; zero when empty.
  assign data_out = empty ? '0 : mem[rd_addr];

  // Pointer advance on accepted operations; reset discards queued words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Error pulses for refused requests, one cycle per offending edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full & ~rd_en;
      underflow <= rd_en & empty;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_fifo_dist.sv
// tb_fifo_dist: directed bench for fifo_dist with a queue reference model.
module tb_fifo_dist;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] data_in;
  logic       rd_en;
  logic [2:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];
  logic       exp_ov;
  logic       exp_un;

  fifo_dist #(
    .DATA_W(3), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count",        32'(count),        32'(n));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == 16));
    chk("almost_full",  32'(almost_full),  32'(n >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("data_out",     32'(data_out),     (n == 0) ? 32'd0 : 32'(exp_q[0]));
    chk("overflow",     32'(overflow),     32'(exp_ov));
    chk("underflow",    32'(underflow),    32'(exp_un));
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic cycle(input logic w, input logic [2:0] d, input logic r);
    int   n;
    logic p_ok;
    logic q_ok;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    n       = exp_q.size();
    p_ok    = w && ((n < 16) || r);
    q_ok    = r && (n > 0);
    exp_ov  = w && (n == 16) && !r;
    exp_un  = r && (n == 0);
    @(posedge clk);
    #1;
    if (q_ok) void'(exp_q.pop_front());
    if (p_ok) exp_q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_all();
  endtask

  initial begin
    logic [2:0] dv;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    exp_ov  = 1'b0;
    exp_un  = 1'b0;

    // Power-on reset values
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Asynchronous reset in the middle of operation with five words queued
    for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i + 2), 1'b0);
    chk("pre_reset_count", 32'(count), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ov = 1'b0;
    exp_un = 1'b0;
    chk("rst_empty",    32'(empty),        32'd1);
    chk("rst_count",    32'(count),        32'd0);
    chk("rst_data",     32'(data_out),     32'd0);
    chk("rst_full",     32'(full),         32'd0);
    chk("rst_aempty",   32'(almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 3'd0, 1'b0);
    cycle(1'b0, 3'd0, 1'b0);

    // Fill with 0..7, 0..7
    for (int i = 0; i < 16; i++) begin
      dv = 3'(i % 8);
      cycle(1'b1, dv, 1'b0);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);

    // Push at full without pop is refused
    cycle(1'b1, 3'b101, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_head",  32'(data_out), 32'd0);
    cycle(1'b0, 3'd0, 1'b0);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain sixteen words in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_head", 32'(data_out), 32'(i % 8));
      cycle(1'b0, 3'd0, 1'b1);
    end
    chk("drain_empty", 32'(empty),    32'd1);
    chk("drain_data",  32'(data_out), 32'd0);

    // Pop at empty is refused
    cycle(1'b0, 3'd0, 1'b1);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count),     32'd0);
    cycle(1'b0, 3'd0, 1'b0);
    chk("unf_clear", 32'(underflow), 32'd0);

    // Push plus pop at empty: push taken, pop refused
    cycle(1'b1, 3'd3, 1'b1);
    chk("ep_count", 32'(count),     32'd1);
    chk("ep_unf",   32'(underflow), 32'd1);
    chk("ep_head",  32'(data_out),  32'd3);

    // Refill to full, then push plus pop at full
    for (int i = 0; i < 15; i++) cycle(1'b1, 3'(i), 1'b0);
    chk("refill_full", 32'(full), 32'd1);
    cycle(1'b1, 3'b110, 1'b1);
    chk("fp_count", 32'(count),    32'd16);
    chk("fp_ovf",   32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fp_last", 32'(data_out), 32'd6);
      cycle(1'b0, 3'd0, 1'b1);
    end

    // Random traffic across pointer wraps
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
